// File: rtl/oserdes_feeder_pkg.sv
// oserdes_feeder_pkg: shared types and helpers for the OSERDES lane feeder.
//   feeder_state_t   - sequencer states
//   PRBS7_TAPS       - x^7 + x^6 + 1 feedback taps (bits 6 and 5)
//   rep_idle()       - replicates one idle word across all lanes
package oserdes_feeder_pkg;

    typedef enum logic [1:0] {IDLE, ALIGN, STREAM, DRAIN} feeder_state_t;

    localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

    // Widest lane bus supported: 16 lanes x 10 bits.
    localparam int MAX_BUS = 160;

    // The result is MAX_BUS wide. Callers keep the low lanes*width bits.
    function automatic logic [MAX_BUS-1:0] rep_idle(input logic [9:0] word,
                                                    input int width,
                                                    input int lanes);
        logic [MAX_BUS-1:0] r;
        logic [9:0]         m;
        r = '0;
        m = 10'((1 << width) - 1);
        for (int k = 0; k < lanes; k++)
            r = (r << width) | {{(MAX_BUS-10){1'b0}}, word & m};
        return r;
    endfunction

endpackage

// File: rtl/oserdes_lane_feeder_if.sv
// oserdes_lane_feeder_if: valid/ready word stream into the lane feeder.
//   in_valid - word valid (master -> slave)
//   in_ready - feeder can accept (slave -> master)
//   in_data  - LANES*WIDTH word; lane k sits at [k*WIDTH +: WIDTH]
interface oserdes_lane_feeder_if #(
    parameter int WIDTH = 4,
    parameter int LANES = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/oserdes_feeder_fifo.sv
// oserdes_feeder_fifo: single-clock FIFO with occupancy count.
//   clock, reset    - clock; synchronous active-high reset
//   flush           - empties the FIFO on the next edge
//   push/wdata      - write, ignored when full
//   pop/rdata       - read; rdata shows the head entry whenever not empty
//   full/empty/level - status
// DEPTH must be a power of two so that the pointers wrap naturally.
module oserdes_feeder_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH+1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end
endmodule

// File: rtl/oserdes_lane_feeder.sv
// oserdes_lane_feeder: buffers wide words and feeds a bank of serializers
// in lock-step, with bonded start, idle fill and underrun detection.
//   clock, reset        - word clock; synchronous active-high reset
//   enable, pll_lock    - stream enable; fast-clock PLL lock
//   in_if (slave)       - in_valid / in_ready / in_data word stream
//   oserdes_d/_load     - registered parallel word and per-lane load strobe
//   bond_sync_in/_out   - channel-bond start pulse (slave in / master out)
//   fifo_level          - FIFO occupancy
//   underrun, clear_status - sticky underrun flag and its clear
// Build option: OSERDES_LANE_FEEDER_PRBS_EN replaces the fixed idle word with
// a free-running PRBS7 word (seed 7'h7F), identical on every lane.
module oserdes_lane_feeder
    import oserdes_feeder_pkg::*;
#(
    parameter int         WIDTH        = 4,
    parameter int         LANES        = 4,
    parameter int         DEPTH        = 8,
    parameter int         START_LEVEL  = 2,
    parameter int         BOND_MASTER  = 1,
    parameter logic [9:0] IDLE_PATTERN = 10'b0101010101
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         pll_lock,
    oserdes_lane_feeder_if.slave         in_if,
    output logic [LANES*WIDTH-1:0]       oserdes_d,
    output logic [LANES-1:0]             oserdes_load,
    input  logic                         bond_sync_in,
    output logic                         bond_sync_out,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         underrun,
    input  logic                         clear_status
);
    localparam int             BUS      = LANES * WIDTH;
    localparam int             LW       = $clog2(DEPTH+1);
    localparam logic [LW-1:0]  START_LV = LW'(START_LEVEL);

    feeder_state_t      state;
    logic               rdy_en, full, empty, pop;
    logic [BUS-1:0]     rdata, idle_bus;
    logic [9:0]         idle_w;
    logic [MAX_BUS-1:0] idle_rep;
    logic               unused_rep;

`ifdef OSERDES_LANE_FEEDER_PRBS_EN
    logic [6:0]       prbs_q, prbs_n;
    logic [WIDTH-1:0] prbs_word;

    // Advance WIDTH bits per word; the first generated bit ends up in the MSB.
    always_comb begin
        prbs_n    = prbs_q;
        prbs_word = '0;
        for (int b = 0; b < WIDTH; b++) begin
            prbs_word = {prbs_word[WIDTH-2:0], ^(prbs_n & PRBS7_TAPS)};
            prbs_n    = {prbs_n[5:0], ^(prbs_n & PRBS7_TAPS)};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) prbs_q <= 7'h7F;
        else       prbs_q <= prbs_n;
    end

    assign idle_w = 10'(prbs_word);
`else
    assign idle_w = IDLE_PATTERN;
`endif

    assign idle_rep   = rep_idle(idle_w, WIDTH, LANES);
    assign idle_bus   = idle_rep[BUS-1:0];
    assign unused_rep = ^idle_rep;

    // rdy_en keeps in_ready low during reset and lets it rise one cycle later.
    assign in_if.in_ready = rdy_en & pll_lock & ~full;
    assign pop = pll_lock & ~empty & ((state == STREAM) || (state == DRAIN));

    oserdes_feeder_fifo #(.DW(BUS), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (~pll_lock),
        .push  (in_if.in_valid & in_if.in_ready),
        .wdata (in_if.in_data),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            oserdes_d     <= idle_bus;
            oserdes_load  <= '0;
            bond_sync_out <= 1'b0;
            underrun      <= 1'b0;
            rdy_en        <= 1'b0;
        end else begin
            rdy_en        <= 1'b1;
            bond_sync_out <= 1'b0;
            oserdes_load  <= '0;
            oserdes_d     <= idle_bus;
            // A same-cycle underrun below overrides this clear.
            if (clear_status) underrun <= 1'b0;

            if (!pll_lock) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable && fifo_level >= START_LV) begin
                            state <= ALIGN;
                            // Master pulses while in ALIGN so bonded slaves
                            // leave ALIGN on the same edge as the master.
                            bond_sync_out <= (BOND_MASTER != 0);
                        end
                    end
                    ALIGN: begin
                        if (!enable)
                            state <= IDLE;
                        else if (BOND_MASTER != 0 || bond_sync_in)
                            state <= STREAM;
                    end
                    STREAM: begin
                        if (!empty) begin
                            oserdes_d    <= rdata;
                            oserdes_load <= '1;
                            if (!enable) state <= DRAIN;
                        end else if (!enable) begin
                            state <= IDLE;
                        end else begin
                            oserdes_load <= '1;
                            underrun     <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                    DRAIN: begin
                        if (!empty) begin
                            oserdes_d    <= rdata;
                            oserdes_load <= '1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_oserdes_lane_feeder.sv
// Directed bench for oserdes_lane_feeder: a bond-master instance (m_*) and a
// bond-slave instance (s_*) with the default 4 lanes x 4 bits, DEPTH 8.
module tb_oserdes_lane_feeder;
    localparam logic [15:0] IDLE16 = 16'h5555;

    logic        clock = 1'b0;
    logic        reset, pll_lock, clear_status;
    logic        m_en, s_en, m_bond_in, s_bond_in;
    logic [15:0] m_d, s_d;
    logic [3:0]  m_load, s_load, m_lvl, s_lvl;
    logic        m_bond_out, s_bond_out, m_urun, s_urun;
    int          errors = 0;
    int          checks = 0;

    oserdes_lane_feeder_if #(.WIDTH(4), .LANES(4)) m_if ();
    oserdes_lane_feeder_if #(.WIDTH(4), .LANES(4)) s_if ();

    always #5 clock = ~clock;

    oserdes_lane_feeder #(.BOND_MASTER(1)) dut (
        .clock(clock), .reset(reset), .enable(m_en), .pll_lock(pll_lock),
        .in_if(m_if.slave), .oserdes_d(m_d), .oserdes_load(m_load),
        .bond_sync_in(m_bond_in), .bond_sync_out(m_bond_out),
        .fifo_level(m_lvl), .underrun(m_urun), .clear_status(clear_status));

    oserdes_lane_feeder #(.BOND_MASTER(0)) dut_s (
        .clock(clock), .reset(reset), .enable(s_en), .pll_lock(pll_lock),
        .in_if(s_if.slave), .oserdes_d(s_d), .oserdes_load(s_load),
        .bond_sync_in(s_bond_in), .bond_sync_out(s_bond_out),
        .fifo_level(s_lvl), .underrun(s_urun), .clear_status(clear_status));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; pll_lock = 1'b1; clear_status = 1'b0;
        m_en = 1'b0; s_en = 1'b0; m_bond_in = 1'b0; s_bond_in = 1'b0;
        m_if.in_valid = 1'b0; m_if.in_data = '0;
        s_if.in_valid = 1'b0; s_if.in_data = '0;
        tick(); tick();

        // Reset state
        chk("rst_ready", m_if.in_ready, 0);
        chk("rst_d",     m_d, IDLE16);
        chk("rst_load",  m_load, 0);
        chk("rst_bond",  m_bond_out, 0);
        chk("rst_level", m_lvl, 0);
        chk("rst_urun",  m_urun, 0);
        reset = 1'b0;
        tick();
        chk("ready_after_rst", m_if.in_ready, 1);

        // Two words, master bond pulse, in-order output, then underrun
        m_if.in_valid = 1'b1; m_if.in_data = 16'hA1B2; tick();
        m_if.in_data = 16'hC3D4; tick();
        m_if.in_valid = 1'b0; m_en = 1'b1;
        chk("lvl2", m_lvl, 2);
        tick(); chk("bond_pulse", m_bond_out, 1); chk("align_load", m_load, 0);
        tick(); chk("bond_low", m_bond_out, 0);
        tick(); chk("w0_d", m_d, 16'hA1B2); chk("w0_load", m_load, 4'hF);
        tick(); chk("w1_d", m_d, 16'hC3D4); chk("w1_load", m_load, 4'hF);
        tick(); chk("urun_d", m_d, IDLE16); chk("urun_load", m_load, 4'hF);
        chk("urun_set", m_urun, 1);
        tick(); chk("idle_load", m_load, 0);
        m_en = 1'b0;

        // clear_status alone clears
        clear_status = 1'b1; tick(); clear_status = 1'b0;
        chk("clear", m_urun, 0);

        // Fill to DEPTH, ninth word refused
        m_if.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_if.in_data = 16'(16'h1111 * (i + 1));
            tick();
        end
        chk("full_lvl", m_lvl, 8);
        chk("full_ready", m_if.in_ready, 0);
        m_if.in_data = 16'hDEAD; tick();
        chk("ninth_lvl", m_lvl, 8);
        m_if.in_valid = 1'b0;

        // Stream, drop enable with 3 queued, drain them
        m_en = 1'b1;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stream_d", m_d, 32'(16'(16'h1111 * (i + 1))));
        end
        chk("lvl3", m_lvl, 3);
        m_en = 1'b0;
        for (int i = 5; i < 8; i++) begin
            tick();
            chk("drain_d", m_d, 32'(16'(16'h1111 * (i + 1))));
            chk("drain_load", m_load, 4'hF);
        end
        tick();
        chk("drain_end_load", m_load, 0);
        chk("drain_urun", m_urun, 0);
        chk("drain_lvl", m_lvl, 0);

        // pll_lock drop with level 5
        m_if.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_if.in_data = 16'(16'h0101 * (i + 1));
            tick();
        end
        m_if.in_valid = 1'b0; m_en = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        chk("pll_pre_lvl", m_lvl, 5);
        chk("pll_pre_load", m_load, 4'hF);
        pll_lock = 1'b0; tick();
        chk("pll_lvl", m_lvl, 0);
        chk("pll_load", m_load, 0);
        chk("pll_ready", m_if.in_ready, 0);
        pll_lock = 1'b1; tick(); tick();
        chk("pll_idle_load", m_load, 0);
        m_en = 1'b0;

        // Underrun set and clear in the same cycle: set wins
        m_if.in_valid = 1'b1; m_if.in_data = 16'h0F0F; tick();
        m_if.in_data = 16'hF0F0; tick();
        m_if.in_valid = 1'b0; m_en = 1'b1;
        tick(); tick(); tick(); tick();
        chk("sc_w1", m_d, 16'hF0F0);
        clear_status = 1'b1; tick(); clear_status = 1'b0;
        chk("set_wins", m_urun, 1);
        chk("set_wins_d", m_d, IDLE16);
        tick();
        clear_status = 1'b1; tick(); clear_status = 1'b0;
        chk("clear_later", m_urun, 0);
        m_en = 1'b0;

        // Slave waits for bond_sync_in
        s_if.in_valid = 1'b1; s_if.in_data = 16'h5A5A; tick();
        s_if.in_data = 16'h3C3C; tick();
        s_if.in_valid = 1'b0; s_en = 1'b1;
        tick();
        chk("slave_no_bond_out", s_bond_out, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("slave_wait_load", s_load, 0);
        end
        s_bond_in = 1'b1; tick(); s_bond_in = 1'b0;
        chk("slave_pulse_load", s_load, 0);
        tick(); chk("slave_w0", s_d, 16'h5A5A); chk("slave_w0_load", s_load, 4'hF);
        tick(); chk("slave_w1", s_d, 16'h3C3C);
        s_en = 1'b0;
        tick(); tick();

        // Reset mid-stream discards queued data
        m_if.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_if.in_data = 16'(16'h2222 * (i + 1));
            tick();
        end
        m_if.in_valid = 1'b0; m_en = 1'b1;
        tick(); tick(); tick();
        chk("mid_lvl", m_lvl, 3);
        reset = 1'b1; tick();
        chk("mid_rst_lvl", m_lvl, 0);
        chk("mid_rst_load", m_load, 0);
        chk("mid_rst_d", m_d, IDLE16);
        chk("mid_rst_ready", m_if.in_ready, 0);
        reset = 1'b0; m_en = 1'b0; tick();
        chk("mid_rst_after", m_lvl, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
